frame_renderer: RTL and testbench

Parametrised raster renderer that walks every pixel of a SCREEN_W x SCREEN_H frame once per start request. For each pixel it emits a registered (x, y, colour, plot) strobe for the VGA adapter. It resolves the player ship, NUM_ENEMIES enemy ships and the bullet grid by fixed priority. It sits between the game-logic FSM, which supplies positions and the grid, and the VGA adapter. It replaces the single-enemy free-running scanner with a start/done handshake and exact W*H coverage.

---
 rtl/frame_renderer.sv | 167 ++++++++++++++++
 tb/tb_frame_renderer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_renderer.sv
// Raster frame renderer: walks SCREEN_W x SCREEN_H pixels per start request and resolves ship/bullet colours by priority.
// Optional border: define BORDER_EN to paint the frame edges in BORDER_COLOUR beneath the ships.
module frame_renderer #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int NUM_ENEMIES = 4,
  parameter int SPRITE_SIZE = 1,
  parameter int COLOUR_BITS = 3,
  parameter logic [COLOUR_BITS-1:0] USER_COLOUR   = 3'b100,
  parameter logic [COLOUR_BITS-1:0] ENEMY_COLOUR  = 3'b001,
  parameter logic [COLOUR_BITS-1:0] BULLET_COLOUR = 3'b010,
  parameter logic [COLOUR_BITS-1:0] BG_COLOUR     = 3'b000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            clear_req,
  input  logic [X_BITS-1:0]               user_x,
  input  logic [Y_BITS-1:0]               user_y,
  input  logic [NUM_ENEMIES*X_BITS-1:0]   enemy_x,
  input  logic [NUM_ENEMIES*Y_BITS-1:0]   enemy_y,
  input  logic [NUM_ENEMIES-1:0]          enemy_alive,
  input  logic [SCREEN_W*SCREEN_H-1:0]    grid,
  output logic [X_BITS-1:0]               x,
  output logic [Y_BITS-1:0]               y,
  output logic [COLOUR_BITS-1:0]          colour,
  output logic                            plot,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int IDX_BITS = $clog2(SCREEN_W*SCREEN_H);
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(SCREEN_W-1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(SCREEN_H-1);
  localparam logic [X_BITS:0]   SPR_X  = (X_BITS+1)'(SPRITE_SIZE);
  localparam logic [Y_BITS:0]   SPR_Y  = (Y_BITS+1)'(SPRITE_SIZE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                   state;
  logic [X_BITS-1:0]            cx;
  logic [Y_BITS-1:0]            cy;
  logic [IDX_BITS-1:0]          idx;

  logic                         clear_q;
  logic [X_BITS-1:0]            user_x_q;
  logic [Y_BITS-1:0]            user_y_q;
  logic [NUM_ENEMIES*X_BITS-1:0] enemy_x_q;
  logic [NUM_ENEMIES*Y_BITS-1:0] enemy_y_q;
  logic [NUM_ENEMIES-1:0]       alive_q;

  logic [X_BITS:0]              udx, edx;
  logic [Y_BITS:0]              udy, edy;
  logic                         user_hit;
  logic                         enemy_hit;
  logic [COLOUR_BITS-1:0]       pix_colour;
  logic                         last_pix;

  assign last_pix = (cx == X_LAST) && (cy == Y_LAST);
  assign busy     = (state != S_IDLE);

  // Differences are one bit wider so a pixel left of / above the anchor wraps large and never hits.
  always_comb begin
    udx       = {1'b0, cx} - {1'b0, user_x_q};
    udy       = {1'b0, cy} - {1'b0, user_y_q};
    user_hit  = (udx < SPR_X) && (udy < SPR_Y);
    enemy_hit = 1'b0;
    edx       = '0;
    edy       = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      edx = {1'b0, cx} - {1'b0, enemy_x_q[i*X_BITS +: X_BITS]};
      edy = {1'b0, cy} - {1'b0, enemy_y_q[i*Y_BITS +: Y_BITS]};
      if (alive_q[i] && (edx < SPR_X) && (edy < SPR_Y)) begin
        enemy_hit = 1'b1;
      end
    end
  end

`ifdef BORDER_EN
  localparam logic [COLOUR_BITS-1:0] BORDER_COLOUR = 3'b111;
  logic on_border;
  assign on_border = (cx == '0) || (cx == X_LAST) || (cy == '0) || (cy == Y_LAST);
`endif

  always_comb begin
    pix_colour = BG_COLOUR;
    if (clear_q) begin
      pix_colour = BG_COLOUR;
    end else if (user_hit) begin
      pix_colour = USER_COLOUR;
    end else if (enemy_hit) begin
      pix_colour = ENEMY_COLOUR;
`ifdef BORDER_EN
    end else if (on_border) begin
      pix_colour = BORDER_COLOUR;
`endif
    end else if (grid[idx]) begin
      pix_colour = BULLET_COLOUR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cx         <= '0;
      cy         <= '0;
      idx        <= '0;
      clear_q    <= 1'b0;
      user_x_q   <= '0;
      user_y_q   <= '0;
      enemy_x_q  <= '0;
      enemy_y_q  <= '0;
      alive_q    <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= BG_COLOUR;
      plot       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      plot       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            clear_q   <= clear_req;
            user_x_q  <= user_x;
            user_y_q  <= user_y;
            enemy_x_q <= enemy_x;
            enemy_y_q <= enemy_y;
            alive_q   <= enemy_alive;
            cx        <= '0;
            cy        <= '0;
            idx       <= '0;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          x      <= cx;
          y      <= cy;
          colour <= pix_colour;
          plot   <= 1'b1;
          if (last_pix) begin
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
            if (cx == X_LAST) begin
              cx <= '0;
              cy <= cy + 1'b1;
            end else begin
              cx <= cx + 1'b1;
            end
          end
        end
        S_DONE: begin
          frame_done <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_renderer.sv
// Bench for frame_renderer: per-pixel scoreboard of every frame plus targeted pixel, handshake and reset checks.
module tb_frame_renderer;

  localparam int W   = 160;
  localparam int H   = 120;
  localparam int XB  = 8;
  localparam int YB  = 7;
  localparam int NE  = 4;
  localparam int SPR = 2;
  localparam int PW  = XB + YB + 3;
`ifdef BORDER_EN
  localparam logic [2:0] EDGE_C = 3'b111;
`else
  localparam logic [2:0] EDGE_C = 3'b000;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              clear_req;
  logic [XB-1:0]     ux;
  logic [YB-1:0]     uy;
  logic [NE*XB-1:0]  ex;
  logic [NE*YB-1:0]  ey;
  logic [NE-1:0]     alive;
  logic [W*H-1:0]    grid;
  logic [XB-1:0]     x;
  logic [YB-1:0]     y;
  logic [2:0]        colour;
  logic              plot;
  logic              busy;
  logic              frame_done;

  frame_renderer #(.SPRITE_SIZE(SPR)) dut (
    .clk(clk), .reset(reset), .start(start), .clear_req(clear_req),
    .user_x(ux), .user_y(uy), .enemy_x(ex), .enemy_y(ey),
    .enemy_alive(alive), .grid(grid),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];
  logic [2:0]    fb [W*H];
  int            plots;
  int            done_cyc;
  int            last_plot_cyc;
  bit            done_seen;
  logic [PW-1:0] first_pix;
  logic [PW-1:0] last_pix;

  // ---------------- reference model ----------------
  function automatic bit in_box(input int px, input int py, input int sx, input int sy);
    return (px >= sx) && (px < sx + SPR) && (py >= sy) && (py < sy + SPR);
  endfunction

  function automatic logic [2:0] model_colour(input int px, input int py);
    if (clear_req) return 3'b000;
    if (in_box(px, py, int'(ux), int'(uy))) return 3'b100;
    for (int i = 0; i < NE; i++)
      if (alive[i] && in_box(px, py, int'(ex[i*XB +: XB]), int'(ey[i*YB +: YB]))) return 3'b001;
`ifdef BORDER_EN
    if (px == 0 || px == W-1 || py == 0 || py == H-1) return 3'b111;
`endif
    if (grid[py*W + px]) return 3'b010;
    return 3'b000;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_frame();
    for (int py = 0; py < H; py++)
      for (int px = 0; px < W; px++)
        exp_q.push_back({XB'(px), YB'(py), model_colour(px, py)});
  endtask

  task automatic set_enemy(input int i, input int sx, input int sy);
    ex[i*XB +: XB] = XB'(sx);
    ey[i*YB +: YB] = YB'(sy);
  endtask

  task automatic random_scene();
    ux = XB'($urandom_range(0, W-1));
    uy = YB'($urandom_range(0, H-1));
    for (int i = 0; i < NE; i++) set_enemy(i, $urandom_range(0, W-1), $urandom_range(0, H-1));
    alive = NE'($urandom_range(0, 15));
    grid  = '0;
    for (int k = 0; k < 40; k++) grid[$urandom_range(0, W*H-1)] = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Pops one expected pixel per plot; optionally re-pulses start or asserts reset at a plot count.
  task automatic drain(input int start_at, input int reset_at);
    int cyc = 0;
    bit start_hi = 0;
    logic [PW-1:0] e;
    plots = 0;
    done_seen = 0;
    while (cyc < 20000 && !done_seen) begin
      @(negedge clk);
      cyc++;
      if (start_hi) begin
        start = 1'b0;
        clear_req = 1'b0;
        start_hi = 0;
      end
      if (plot) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pixel_extra: got (%0d,%0d) colour %b, none expected", x, y, colour);
        end else begin
          e = exp_q.pop_front();
          if ({x, y, colour} !== e) begin
            n_err++;
            $display("FAIL pixel: got (%0d,%0d) c=%b, expected (%0d,%0d) c=%b",
                     x, y, colour, e[PW-1 -: XB], e[3 +: YB], e[2:0]);
          end
        end
        if (int'(x) < W && int'(y) < H) fb[int'(y)*W + int'(x)] = colour;
        if (plots == 0) first_pix = {x, y, colour};
        last_pix = {x, y, colour};
        plots++;
        last_plot_cyc = cyc;
        if (plots == start_at) begin
          start = 1'b1;
          clear_req = 1'b1;
          start_hi = 1;
        end
        if (plots == reset_at) begin
          reset = 1'b1;
          #1;
          n_vec++;
          if (plot !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_frame: plot=%b busy=%b, expected 0 0", plot, busy);
          end
          exp_q.delete();
          return;
        end
      end
      if (frame_done) begin
        done_seen = 1;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic check_pix(input string name, input int px, input int py, input logic [2:0] c);
    n_vec++;
    if (fb[py*W + px] !== c) begin
      n_err++;
      $display("FAIL %s: pixel (%0d,%0d) colour %b, expected %b", name, px, py, fb[py*W + px], c);
    end
  endtask

  task automatic check_frame_end(input string name);
    n_vec++;
    if (!done_seen) begin
      n_err++;
      $display("FAIL %s_timeout: frame_done not seen, plots=%0d", name, plots);
      return;
    end
    n_vec++;
    if (plots !== W*H) begin
      n_err++;
      $display("FAIL %s_plot_count: got %0d, expected %0d", name, plots, W*H);
    end
    n_vec++;
    if (done_cyc !== last_plot_cyc + 1) begin
      n_err++;
      $display("FAIL %s_done_timing: frame_done at %0d, expected %0d", name, done_cyc, last_plot_cyc + 1);
    end
    n_vec++;
    if (busy !== 1'b0 || plot !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle: busy=%b plot=%b at frame_done, expected 0 0", name, busy, plot);
    end
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done_pulse: frame_done=%b after one cycle, expected 0", name, frame_done);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing: %0d pixels never plotted, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_busy_after_start(input string name);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_busy: busy=%b after start, expected 1", name, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; clear_req = 1'b0;
    ux = '0; uy = '0; ex = '0; ey = '0; alive = '0; grid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({x, y, colour, plot, busy, frame_done} !== '0) begin
      n_err++;
      $display("FAIL reset_state: x=%0d y=%0d c=%b plot=%b busy=%b done=%b, expected all 0",
               x, y, colour, plot, busy, frame_done);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: plot=%b busy=%b without start, expected 0 0", plot, busy);
    end
  endtask

  task automatic test_clear_frame();
    random_scene();
    alive = 4'b1111;
    clear_req = 1'b1;
    push_frame();
    pulse_start();
    clear_req = 1'b0;
    check_busy_after_start("clear");
    drain(0, 0);
    n_vec++;
    if (first_pix !== {8'd0, 7'd0, 3'b000} || last_pix !== {8'd159, 7'd119, 3'b000}) begin
      n_err++;
      $display("FAIL clear_ends: first %h last %h, expected %h %h", first_pix, last_pix,
               {8'd0, 7'd0, 3'b000}, {8'd159, 7'd119, 3'b000});
    end
    check_frame_end("clear");
  endtask

  task automatic test_priority();
    clear_req = 1'b0;
    ux = 8'd10; uy = 7'd5;
    set_enemy(0, 10, 5);
    set_enemy(1, 50, 50);
    set_enemy(2, 159, 119);
    set_enemy(3, 70, 80);
    alive = 4'b0111;
    grid = '0;
    grid[5*W + 10]   = 1'b1;
    grid[51*W + 51]  = 1'b1;
    grid[100*W + 100] = 1'b1;
    push_frame();
    pulse_start();
    check_busy_after_start("priority");
    drain(0, 0);
    check_frame_end("priority");
    check_pix("player_over_all", 10, 5, 3'b100);
    check_pix("player_sprite", 11, 6, 3'b100);
    check_pix("enemy_corner", 159, 119, 3'b001);
    check_pix("enemy_over_bullet", 51, 51, 3'b001);
    check_pix("bullet", 100, 100, 3'b010);
    check_pix("dead_enemy", 70, 80, 3'b000);
    n_vec++;
    if (fb[0] === 3'b001 || fb[119*W] === 3'b001 || fb[159] === 3'b001) begin
      n_err++;
      $display("FAIL clip_no_wrap: (0,0)=%b (0,119)=%b (159,0)=%b, expected none 001",
               fb[0], fb[119*W], fb[159]);
    end
  endtask

  task automatic test_dead_and_restart();
    clear_req = 1'b0;
    ux = 8'd80; uy = 7'd60;
    set_enemy(0, 40, 40);
    set_enemy(1, 41, 90);
    set_enemy(2, 120, 10);
    set_enemy(3, 60, 100);
    alive = 4'b0000;
    grid = '0;
    grid[20*W + 30] = 1'b1;
    push_frame();
    pulse_start();
    check_busy_after_start("restart");
    drain(500, 0);
    check_frame_end("restart");
    check_pix("grid_bullet", 30, 20, 3'b010);
    check_pix("dead_e0", 40, 40, 3'b000);
    check_pix("dead_e1", 41, 90, 3'b000);
    check_pix("dead_e2", 120, 10, 3'b000);
    check_pix("dead_e3", 60, 100, 3'b000);
    check_pix("edge_left", 0, 60, EDGE_C);
    check_pix("edge_top", 159, 0, EDGE_C);
    check_pix("inner", 1, 1, 3'b000);
  endtask

  task automatic test_reset_mid_frame();
    random_scene();
    clear_req = 1'b0;
    push_frame();
    pulse_start();
    check_busy_after_start("abort");
    drain(0, 1000);
    n_vec++;
    if (plots !== 1000) begin
      n_err++;
      $display("FAIL abort_reach: reached %0d plots, expected 1000", plots);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b0;
      n_vec++;
      if (frame_done !== 1'b0 || plot !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_quiet: done=%b plot=%b busy=%b, expected 0 0 0", frame_done, plot, busy);
      end
    end
    pulse_start();
    check_busy_after_start("recover");
    @(negedge clk);
    n_vec++;
    if (plot !== 1'b1 || x !== 8'd0 || y !== 7'd0) begin
      n_err++;
      $display("FAIL recover_first: plot=%b (%0d,%0d), expected 1 (0,0)", plot, x, y);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clear_frame();
    test_priority();
    test_dead_and_restart();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
